// File: rtl/skein_pkg.sv
// rtl/skein_pkg.sv - shared Skein word/block geometry and serializer state encoding
package skein_pkg;

  localparam int WORD_W    = 64;
  localparam int NUM_WORDS = 16;
  localparam int BLOCK_W   = WORD_W * NUM_WORDS;
  localparam int IDX_W     = 4;

  // Shared with key_register so both ends agree on word order and state meaning.
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } ser_state_e;

endpackage

// File: rtl/key_serializer.sv
// rtl/key_serializer.sv - 1024-bit block to sixteen 64-bit words, LS word first, valid/ready out
module key_serializer
  import skein_pkg::*;
(
  input  logic               clk_i,
  input  logic               rst_n_i,
  input  logic               load_i,
  input  logic [BLOCK_W-1:0] block_i,
  output logic               ready_o,
  output logic [WORD_W-1:0]  word_o,
  output logic               valid_o,
  input  logic               ready_i,
  output logic [IDX_W-1:0]   idx_o,
  output logic               last_o,
  output logic               done_o
);

  ser_state_e         state_q, state_d;
  logic [BLOCK_W-1:0] shift_q;
  logic [IDX_W-1:0]   idx_q;
  logic               done_q;
  logic               beat;
  logic               last_beat;
  logic               at_last;

  assign at_last   = (idx_q == IDX_W'(NUM_WORDS - 1));
  assign beat      = (state_q == ST_SEND) && ready_i;
  assign last_beat = beat && at_last;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (load_i)    state_d = ST_SEND;
      ST_SEND: if (last_beat) state_d = ST_IDLE;
      default:                state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= ST_IDLE;
      shift_q <= '0;
      idx_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= last_beat;
      if ((state_q == ST_IDLE) && load_i) begin
        shift_q <= block_i;
        idx_q   <= '0;
      end else if (beat) begin
        shift_q <= {{WORD_W{1'b0}}, shift_q[BLOCK_W-1:WORD_W]};
        // Index parks at 0 after the final word instead of wrapping.
        idx_q   <= at_last ? '0 : idx_q + IDX_W'(1);
      end
    end
  end

  // ready_o comes only from state, so there is no ready_i -> ready_o path.
  assign ready_o = (state_q == ST_IDLE);
  assign valid_o = (state_q == ST_SEND);
  assign word_o  = shift_q[WORD_W-1:0];
  assign idx_o   = idx_q;
  assign last_o  = valid_o && at_last;
  assign done_o  = done_q;

endmodule

// File: tb/tb_key_serializer.sv
// tb/tb_key_serializer.sv - scoreboard bench for key_serializer
module tb_key_serializer;

  logic          clk = 1'b0;
  logic          rst_n_i = 1'b0;
  logic          load_i = 1'b0;
  logic [1023:0] block_i = '0;
  logic          ready_o;
  logic [63:0]   word_o;
  logic          valid_o;
  logic          ready_i = 1'b0;
  logic [3:0]    idx_o;
  logic          last_o;
  logic          done_o;

  key_serializer dut (
    .clk_i   (clk),
    .rst_n_i (rst_n_i),
    .load_i  (load_i),
    .block_i (block_i),
    .ready_o (ready_o),
    .word_o  (word_o),
    .valid_o (valid_o),
    .ready_i (ready_i),
    .idx_o   (idx_o),
    .last_o  (last_o),
    .done_o  (done_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] w;
    logic [3:0]  idx;
    logic        last;
  } exp_t;

  exp_t          sb[$];
  logic [1023:0] blk_q[$];
  int            n_pass = 0;
  int            n_total = 0;
  int            n_beats = 0;
  int            cyc_cnt = 0;

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endfunction

  function automatic void check_blk(string name, logic [1023:0] act, logic [1023:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else begin
      for (int k = 0; k < 16; k++) begin
        if (act[64*k +: 64] !== exp[64*k +: 64]) begin
          $display("FAIL %s: word %0d got %h expected %h", name, k, act[64*k +: 64], exp[64*k +: 64]);
          break;
        end
      end
    end
  endfunction

  // Monitor: pops the scoreboard on every beat, checks stall stability and done timing.
  logic          done_pending = 1'b0;
  logic          prev_stall = 1'b0;
  logic [63:0]   prev_word = '0;
  logic [3:0]    prev_idx = '0;
  logic [1023:0] rx = '0;
  exp_t          e;

  always @(negedge clk) begin
    if (!rst_n_i) begin
      done_pending = 1'b0;
      prev_stall   = 1'b0;
      rx           = '0;
    end else begin
      if (done_pending || done_o) check("done_timing", 64'(done_o), 64'(done_pending));
      done_pending = 1'b0;
      if (valid_o && prev_stall) begin
        check("stall_word", word_o, prev_word);
        check("stall_idx", 64'(idx_o), 64'(prev_idx));
      end
      if (valid_o && ready_i) begin
        n_beats++;
        if (sb.size() == 0) check("unexpected_beat", 64'(idx_o), 64'hFFFF);
        else begin
          e = sb.pop_front();
          check("word", word_o, e.w);
          check("idx", 64'(idx_o), 64'(e.idx));
          check("last", 64'(last_o), 64'(e.last));
        end
        rx[64*idx_o +: 64] = word_o;
        if (last_o) begin
          done_pending = 1'b1;
          if (blk_q.size() != 0) check_blk("roundtrip", rx, blk_q.pop_front());
        end
      end else if (last_o && !valid_o) begin
        check("last_without_valid", 64'(last_o), 64'h0);
      end
      prev_stall = valid_o && !ready_i;
      prev_word  = word_o;
      prev_idx   = idx_o;
    end
  end

  int load_cyc;

  task automatic do_load(input logic [1023:0] b);
    exp_t x;
    for (int t = 0; t < 100 && !ready_o; t++) begin
      @(posedge clk); #1;
    end
    check("ready_before_load", 64'(ready_o), 64'h1);
    for (int k = 0; k < 16; k++) begin
      x.w = b[64*k +: 64];
      x.idx = 4'(k);
      x.last = (k == 15);
      sb.push_back(x);
    end
    blk_q.push_back(b);
    load_i  = 1'b1;
    block_i = b;
    @(posedge clk); #1;
    load_i  = 1'b0;
    block_i = $urandom;
    load_cyc = cyc_cnt;
    check("first_valid", 64'(valid_o), 64'h1);
    check("first_idx", 64'(idx_o), 64'h0);
    check("busy_ready", 64'(ready_o), 64'h0);
  endtask

  // mode 0: ready always 1; mode 1: 1,0,0,1 pattern; mode 2: random
  task automatic run(input int mode, input int busy_at, output int cyc);
    logic [3:0] pat;
    bit got;
    pat = 4'b1001;
    got = 0;
    cyc = 1;
    for (int t = 0; t < 300; t++) begin
      if (done_o) begin
        got = 1;
        break;
      end
      ready_i = (mode == 0) ? 1'b1 : (mode == 1) ? pat[(cyc - 1) % 4] : 1'($urandom_range(0, 1));
      if (cyc == busy_at) begin
        load_i  = 1'b1;
        block_i = '1;
        check("ready_low_busy", 64'(ready_o), 64'h0);
      end
      @(posedge clk); #1;
      load_i = 1'b0;
      cyc++;
    end
    if (!got) check("done_timeout", 64'h0, 64'h1);
  endtask

  logic [1023:0] basic_blk, rnd_blk;
  int cyc, t1, b0;

  initial begin
    for (int k = 0; k < 16; k++) basic_blk[64*k +: 64] = 64'hA5A5_0000_0000_0000 + 64'(k);

    #1;
    check("rst_ready", 64'(ready_o), 64'h1);
    check("rst_valid", 64'(valid_o), 64'h0);
    check("rst_word", word_o, 64'h0);
    check("rst_idx", 64'(idx_o), 64'h0);
    check("rst_last", 64'(last_o), 64'h0);
    check("rst_done", 64'(done_o), 64'h0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n_i = 1'b1;
    @(posedge clk); #1;

    // Basic order: done 17 cycles after the load edge
    b0 = n_beats;
    do_load(basic_blk);
    run(0, 0, cyc);
    check("basic_done_cycle", 64'(cyc), 64'd17);
    check("basic_ready_back", 64'(ready_o), 64'h1);
    check("basic_beats", 64'(n_beats - b0), 64'd16);

    // Back-pressure
    @(posedge clk); #1;
    b0 = n_beats;
    do_load(basic_blk);
    run(1, 0, cyc);
    check("bp_beats", 64'(n_beats - b0), 64'd16);
    check("bp_sb_empty", 64'(sb.size()), 64'h0);

    // Load while busy (word 5 on output), then back-to-back on the done cycle
    @(posedge clk); #1;
    do_load(basic_blk);
    t1 = load_cyc;
    run(0, 6, cyc);
    check("busy_done_cycle", 64'(cyc), 64'd17);
    check("b2b_done_high", 64'(done_o), 64'h1);
    for (int k = 0; k < 16; k++) rnd_blk[32*2*k +: 64] = {$urandom, $urandom};
    do_load(rnd_blk);
    check("b2b_spacing", 64'(load_cyc - t1), 64'd17);
    run(0, 0, cyc);

    // Reset after beat 7
    @(posedge clk); #1;
    do_load(basic_blk);
    for (int k = 0; k < 8; k++) begin
      ready_i = 1'b1;
      @(posedge clk); #1;
    end
    check("pre_rst_idx", 64'(idx_o), 64'd8);
    rst_n_i = 1'b0;
    sb.delete();
    blk_q.delete();
    #1;
    check("mid_rst_valid", 64'(valid_o), 64'h0);
    check("mid_rst_ready", 64'(ready_o), 64'h1);
    check("mid_rst_word", word_o, 64'h0);
    check("mid_rst_idx", 64'(idx_o), 64'h0);
    for (int k = 0; k < 2; k++) begin
      @(posedge clk); #1;
      check("mid_rst_no_done", 64'(done_o), 64'h0);
    end
    rst_n_i = 1'b1;
    @(posedge clk); #1;
    check("post_rst_no_done", 64'(done_o), 64'h0);
    do_load(basic_blk);
    run(0, 0, cyc);
    check("post_rst_done_cycle", 64'(cyc), 64'd17);

    // Loopback with random blocks and random back-pressure
    for (int i = 0; i < 30; i++) begin
      for (int k = 0; k < 16; k++) rnd_blk[64*k +: 64] = {$urandom, $urandom};
      do_load(rnd_blk);
      run(2, 0, cyc);
    end
    @(posedge clk); #1;
    check("final_sb_empty", 64'(sb.size()), 64'h0);
    check("final_blk_empty", 64'(blk_q.size()), 64'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
